// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path: state encoding,
// instruction class codes and datapath mux select values.
package cpu_ctrl_pkg;

   // 4-bit state encoding; the values are visible on state_o for debug.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_e;

   // Instruction class (Op field)
   localparam logic [1:0] OP_DP     = 2'b00;
   localparam logic [1:0] OP_MEM    = 2'b01;
   localparam logic [1:0] OP_BRANCH = 2'b10;
   localparam logic [1:0] OP_UNDEF  = 2'b11;

   // ALU operand A select
   localparam logic SRCA_REG = 1'b0;
   localparam logic SRCA_PC  = 1'b1;

   // ALU operand B select
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // Memory address select
   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_RESULT = 1'b1;

   // States that wait on mem_ready and are supervised by the wait counter.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Saturating memory wait-cycle counter with a limit-reached flag.
module mem_wait_counter #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic limit_o
);

   localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear has priority; counting stops once the limit is reached.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != LIM)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Counter register, forced to zero while reset is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign limit_o = (cnt_q == LIM);

endmodule

// File: rtl/main_fsm.sv
// Multicycle CPU main controller: sequences fetch/decode/execute and
// drives datapath strobes, with a memory wait timeout raising bus_err.
module main_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       ALUOp,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       undef_op,
   output logic       bus_err,
   output logic [3:0] state_o
);

   state_e state_q;
   state_e state_d;
   logic   limit_reached;
   logic   timeout;
   logic   cnt_clear;
   logic   cnt_enable;

   mem_wait_counter #(.LIMIT(WAIT_LIMIT)) u_wait (
      .clk      (clk),
      .rst_n    (reset),
      .clear_i  (cnt_clear),
      .enable_i (cnt_enable),
      .limit_o  (limit_reached)
   );

   // A wait state that has exhausted its budget and still sees no ready.
   assign timeout = is_wait_state(state_q) && !mem_ready && limit_reached;

   // Restart the count on every entry into a wait state, including the
   // FETCH->FETCH re-entry after a timeout.
   assign cnt_clear  = is_wait_state(state_d) && ((state_d != state_q) || timeout);
   assign cnt_enable = is_wait_state(state_q) && !mem_ready;

   // Next-state and Moore/ready-gated output decode.
   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      AdrSrc    = ADR_PC;
      ALUSrcA   = SRCA_REG;
      ALUSrcB   = SRCB_REG;
      ResultSrc = RES_ALUOUT;
      undef_op  = 1'b0;
      bus_err   = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            AdrSrc    = ADR_PC;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            IRWrite   = mem_ready;
            NextPC    = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            case (Op)
               OP_MEM:    state_d = S_MEMADR;
               OP_DP:     state_d = Funct[5] ? S_EXECI : S_EXECR;
               OP_BRANCH: state_d = S_BRANCH;
               default: begin
                  undef_op = 1'b1;
                  state_d  = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_IMM;
            state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req   = 1'b1;
            AdrSrc    = ADR_RESULT;
            ResultSrc = RES_ALUOUT;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegW      = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            AdrSrc    = ADR_RESULT;
            ResultSrc = RES_ALUOUT;
            MemW      = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_REG;
            ALUOp   = 1'b1;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_IMM;
            ALUOp   = 1'b1;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            RegW      = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA   = SRCA_REG;
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALU;
            Branch    = 1'b1;
            state_d   = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      // Timeout abandons the access; completion strobes are already low
      // because mem_ready is low, but keep them explicitly suppressed.
      if (timeout) begin
         bus_err = 1'b1;
         IRWrite = 1'b0;
         NextPC  = 1'b0;
         MemW    = 1'b0;
         RegW    = 1'b0;
         state_d = S_FETCH;
      end
   end

   // State register; reset low returns to FETCH at once, even mid-instruction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: maximum memory wait cycles before a bus error is flagged.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-low.
REQ-004 Op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 Funct  input  6  Funct[5] immediate (I) bit, Funct[0] load/S bit.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 mem_req  output  1  memory access request.
REQ-008 IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc  output  1 each  datapath/Condlogic strobes and selects.
REQ-009 ALUSrcA  output  1; ALUSrcB, ResultSrc  output  2 each  datapath mux selects.
REQ-010 undef_op  output  1  one-cycle pulse on Op=11 in DECODE.
REQ-011 bus_err  output  1  one-cycle pulse on memory wait timeout.
REQ-012 state_o  output  4  current state encoding, debug.

Function
REQ-013 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
REQ-014 Unlisted outputs are 0 in each state; outputs are decoded from state, gated by mem_ready only where stated.
REQ-015 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0; IRWrite=NextPC=mem_ready.
REQ-016 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
REQ-017 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
REQ-018 MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00.
REQ-019 MEMWB: ResultSrc=01, RegW=1.
REQ-020 MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00, MemW=mem_ready.
REQ-021 EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1; EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
REQ-022 ALUWB: ResultSrc=00, RegW=1.
REQ-023 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1.
REQ-024 FETCH->DECODE when mem_ready=1, else stay.
REQ-025 DECODE-> MEMADR (Op=01), EXECR (Op=00, Funct[5]=0), EXECI (Op=00, Funct[5]=1), BRANCH (Op=10), FETCH with undef_op=1 (Op=11).
REQ-026 MEMADR->MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-027 MEMREAD->MEMWB and MEMWRITE->FETCH when mem_ready=1, else stay.
REQ-028 MEMWB, ALUWB, BRANCH->FETCH; EXECR, EXECI->ALUWB; all unconditional, one cycle each.
REQ-029 Wait counter: cleared on entry to FETCH/MEMREAD/MEMWRITE, increments each cycle mem_ready=0 in those states, saturates.
REQ-030 When counter equals WAIT_LIMIT with mem_ready=0: bus_err=1 for one cycle, next state FETCH, no IRWrite/NextPC/MemW/RegW issued.
REQ-031 mem_ready=1 on the timeout cycle wins: normal completion, no bus_err.
REQ-032 Illegal state encodings SHALL transition to FETCH next cycle.
REQ-033 Latencies with zero wait: load 5 cycles, store 4, ALU 4, branch 3.

Reset
REQ-034 reset low forces state FETCH and wait counter 0 asynchronously, including mid-instruction.
REQ-035 During and after reset: mem_req=1, IRWrite=NextPC=mem_ready, RegW=MemW=Branch=0, undef_op=bus_err=0, state_o=FETCH encoding.

Structure
REQ-036 State enum (4-bit), Op class constants and mux select constants SHALL live in shared package cpu_ctrl_pkg.
REQ-037 Wait counter SHALL be sub-module mem_wait_counter (clear, enable, limit-reached output).
REQ-038 RegW, MemW, Branch feed Condlogic unconditional; condition gating stays outside main_fsm.

Verification
REQ-039 Load: Op=01, Funct[0]=1, mem_ready=1 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegW=1 with ResultSrc=01 in cycle 5 only.
REQ-040 Store with 3 wait cycles in MEMWRITE -> MEMWRITE held 4 cycles, MemW=1 only in final cycle, then FETCH.
REQ-041 Op=00, Funct[5]=1 -> EXECI then ALUWB with ALUSrcB=01, ALUOp=1, RegW=1 in ALUWB.
REQ-042 Op=11 in DECODE -> undef_op pulse one cycle, next state FETCH, no RegW/MemW.
REQ-043 mem_ready held 0 in FETCH with WAIT_LIMIT=15 -> bus_err in cycle 16, IRWrite never 1, back to FETCH with counter 0.
REQ-044 reset low asserted in MEMREAD -> immediately state_o=FETCH, RegW=0; release resumes normal fetch.
